// File: rtl/plab3_mem_nsbit_mem_responder_pkg.sv
// rtl/plab3_mem_nsbit_mem_responder_pkg.sv - shared vc-mem-msgs field widths, encodings and responder FSM states
package plab3_mem_nsbit_mem_responder_pkg;

  localparam int unsigned c_mem_type_nbits  = 3;
  localparam int unsigned c_mem_addr_nbits  = 32;
  localparam int unsigned c_mem_len_nbits   = 4;
  localparam int unsigned c_mem_data_nbits  = 128;
  localparam int unsigned c_mem_line_nbytes = 16;

  localparam logic [2:0] c_mem_type_read  = 3'd0;
  localparam logic [2:0] c_mem_type_write = 3'd1;

  localparam logic c_mem_domain_normal = 1'b0;
  localparam logic c_mem_domain_secure = 1'b1;

  // Request layout, MSB first: {type, opaque, addr, len, data}
  function automatic int unsigned mem_req_msg_nbits(input int unsigned o);
    return c_mem_type_nbits + o + c_mem_addr_nbits + c_mem_len_nbits + c_mem_data_nbits;
  endfunction

  // Response layout, MSB first: {type, opaque, len, data}
  function automatic int unsigned mem_resp_msg_nbits(input int unsigned o);
    return c_mem_type_nbits + o + c_mem_len_nbits + c_mem_data_nbits;
  endfunction

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  // Bytes offset..offset+n-1 of one line; anything past byte 15 is dropped, never wrapped
  function automatic logic [15:0] write_byte_en(input logic [3:0] offset, input logic [3:0] len);
    logic [4:0]  nbytes;
    logic [15:0] mask;
    nbytes = (len == 4'd0) ? 5'd16 : {1'b0, len};
    mask   = '0;
    for (int i = 0; i < 16; i++) begin
      if ((5'(i) >= {1'b0, offset}) && (5'(i) < ({1'b0, offset} + nbytes)))
        mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/plab3_mem_nsbit_mem_array.sv
// rtl/plab3_mem_nsbit_mem_array.sv - 128-bit line storage, one async read port, one byte-enabled write port
module plab3_mem_nsbit_mem_array #(
  parameter int unsigned p_idx_nbits = 6
)(
  input  logic                   clk,
  input  logic [p_idx_nbits-1:0] rd_idx,
  output logic [127:0]           rd_data,
  input  logic                   wr_en,
  input  logic [p_idx_nbits-1:0] wr_idx,
  input  logic [15:0]            wr_byte_en,
  input  logic [127:0]           wr_data
);

  localparam int unsigned c_nlines = 1 << p_idx_nbits;

  logic [127:0] mem [c_nlines];

  assign rd_data = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 16; b++) begin
        if (wr_byte_en[b])
          mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/plab3_mem_nsbit_mem_responder.sv
// rtl/plab3_mem_nsbit_mem_responder.sv - single-outstanding memory responder with fixed latency
// PLAB3_MEM_NSBIT_CHECK_EN enables normal-domain blocking of secure storage and the viol_count port.
module plab3_mem_nsbit_mem_responder
  import plab3_mem_nsbit_mem_responder_pkg::*;
#(
  parameter int unsigned p_mem_nbytes   = 1024,
  parameter int unsigned p_opaque_nbits = 8,
  parameter int unsigned p_latency      = 2,
  parameter logic [31:0] p_secure_base  = 32'h200
)(
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [mem_req_msg_nbits(p_opaque_nbits)-1:0]  memreq_msg,
  input  logic                                          memreq_domain,
  input  logic                                          memreq_val,
  output logic                                          memreq_rdy,
  output logic [mem_resp_msg_nbits(p_opaque_nbits)-1:0] memresp_msg,
  output logic                                          memresp_domain,
  output logic                                          memresp_val,
  input  logic                                          memresp_rdy
`ifdef PLAB3_MEM_NSBIT_CHECK_EN
  ,
  output logic [7:0]                                    viol_count
`endif
);

  localparam int unsigned c_req_nbits  = mem_req_msg_nbits(p_opaque_nbits);
  localparam int unsigned c_addr_nbits = $clog2(p_mem_nbytes);
  localparam int unsigned c_idx_nbits  = c_addr_nbits - 4;
  localparam int unsigned c_len_lsb    = c_mem_data_nbits;
  localparam int unsigned c_addr_lsb   = c_len_lsb + c_mem_len_nbits;
  localparam int unsigned c_opq_lsb    = c_addr_lsb + c_mem_addr_nbits;
  localparam int unsigned c_type_lsb   = c_opq_lsb + p_opaque_nbits;
  localparam logic [31:0] c_addr_mask  = 32'(p_mem_nbytes - 1);
  localparam logic [3:0]  c_latency    = 4'(p_latency);

  state_t                    state;
  logic [3:0]                cnt;
  logic [c_req_nbits:0]      req_q;

  logic [2:0]                in_type;
  logic [31:0]               in_addr;
  logic [3:0]                in_len;
  logic [127:0]              in_data;
  logic                      req_domain;
  logic [2:0]                req_type;
  logic [p_opaque_nbits-1:0] req_opaque;
  logic [31:0]               req_addr;
  logic [3:0]                req_len;

  logic                      accept;
  logic                      in_blocked;
  logic                      req_blocked;
  logic                      wr_en;
  logic [127:0]              rd_data;
  logic [127:0]              resp_data;

  assign in_type    = memreq_msg[c_type_lsb +: c_mem_type_nbits];
  assign in_addr    = memreq_msg[c_addr_lsb +: c_mem_addr_nbits];
  assign in_len     = memreq_msg[c_len_lsb +: c_mem_len_nbits];
  assign in_data    = memreq_msg[0 +: c_mem_data_nbits];

  assign req_domain = req_q[c_req_nbits];
  assign req_type   = req_q[c_type_lsb +: c_mem_type_nbits];
  assign req_opaque = req_q[c_opq_lsb +: p_opaque_nbits];
  assign req_addr   = req_q[c_addr_lsb +: c_mem_addr_nbits];
  assign req_len    = req_q[c_len_lsb +: c_mem_len_nbits];

  assign accept = memreq_val && memreq_rdy;

`ifdef PLAB3_MEM_NSBIT_CHECK_EN
  assign in_blocked  = (memreq_domain == c_mem_domain_normal) && ((in_addr & c_addr_mask) >= p_secure_base);
  assign req_blocked = (req_domain == c_mem_domain_normal) && ((req_addr & c_addr_mask) >= p_secure_base);
`else
  assign in_blocked  = 1'b0;
  assign req_blocked = 1'b0;
`endif

  // Address bits above the array and the latched write data are intentionally dropped
  logic unused_bits;
  assign unused_bits = ^{in_addr, req_addr, req_q[c_mem_data_nbits-1:0]};

  // Writes commit on the accept edge so a later read observes them
  assign wr_en = accept && (in_type == c_mem_type_write) && !in_blocked;

  plab3_mem_nsbit_mem_array #(
    .p_idx_nbits (c_idx_nbits)
  ) u_array (
    .clk        (clk),
    .rd_idx     (req_addr[c_addr_nbits-1:4]),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_idx     (in_addr[c_addr_nbits-1:4]),
    .wr_byte_en (write_byte_en(in_addr[3:0], in_len)),
    .wr_data    (in_data << {in_addr[3:0], 3'b000})
  );

  assign resp_data      = ((req_type == c_mem_type_write) || req_blocked) ? '0 : rd_data;
  assign memresp_domain = req_domain;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      memresp_val <= 1'b0;
      memresp_msg <= '0;
      memreq_rdy  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_q      <= {memreq_domain, memreq_msg};
            memreq_rdy <= 1'b0;
            if (p_latency > 0) begin
              state <= ST_WAIT;
              cnt   <= c_latency;
            end else begin
              state <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1)
            state <= ST_RESP;
        end
        ST_RESP: begin
          // First RESP cycle loads the response; it then holds until the handshake
          if (!memresp_val) begin
            memresp_val <= 1'b1;
            memresp_msg <= {req_type, req_opaque, req_len, resp_data};
          end else if (memresp_rdy) begin
            memresp_val <= 1'b0;
            memreq_rdy  <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PLAB3_MEM_NSBIT_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset)
      viol_count <= '0;
    else if (accept && in_blocked && (viol_count != 8'hFF))
      viol_count <= viol_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_plab3_mem_nsbit_mem_responder.sv
// tb/tb_plab3_mem_nsbit_mem_responder.sv - self-checking bench: vector table, response scoreboard, corner sequences
module tb_plab3_mem_nsbit_mem_responder;
  import plab3_mem_nsbit_mem_responder_pkg::*;

  localparam int unsigned c_o          = 8;
  localparam int unsigned c_req_nbits  = mem_req_msg_nbits(c_o);
  localparam int unsigned c_resp_nbits = mem_resp_msg_nbits(c_o);
  localparam int          c_lat        = 2;

  localparam logic [127:0] c_d1   = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] c_d2   = 128'h0123456789ABCDEF0123EE6789ABCDEF;
  localparam logic [127:0] c_l30  = 128'h22115555555555555555555555555555;
  localparam logic [127:0] c_all5 = {16{8'h55}};
  localparam logic [127:0] c_all7 = {16{8'h77}};
  localparam logic [127:0] c_allA = {16{8'hAA}};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [c_req_nbits-1:0]  memreq_msg;
  logic                    memreq_domain;
  logic                    memreq_val;
  logic                    memreq_rdy;
  logic [c_resp_nbits-1:0] memresp_msg;
  logic                    memresp_domain;
  logic                    memresp_val;
  logic                    memresp_rdy;

  logic [c_req_nbits-1:0]  memreq_msg_z;
  logic                    memreq_domain_z;
  logic                    memreq_val_z;
  logic                    memreq_rdy_z;
  logic [c_resp_nbits-1:0] memresp_msg_z;
  logic                    memresp_domain_z;
  logic                    memresp_val_z;
  logic                    memresp_rdy_z;

`ifdef PLAB3_MEM_NSBIT_CHECK_EN
  logic [7:0] viol_count;
  logic [7:0] viol_count_z;
`endif

  plab3_mem_nsbit_mem_responder #(
    .p_mem_nbytes(1024), .p_opaque_nbits(c_o), .p_latency(c_lat), .p_secure_base(32'h200)
  ) dut (
    .clk(clk), .reset(reset),
    .memreq_msg(memreq_msg), .memreq_domain(memreq_domain), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
    .memresp_msg(memresp_msg), .memresp_domain(memresp_domain), .memresp_val(memresp_val), .memresp_rdy(memresp_rdy)
`ifdef PLAB3_MEM_NSBIT_CHECK_EN
    , .viol_count(viol_count)
`endif
  );

  plab3_mem_nsbit_mem_responder #(
    .p_mem_nbytes(1024), .p_opaque_nbits(c_o), .p_latency(0), .p_secure_base(32'h200)
  ) dut0 (
    .clk(clk), .reset(reset),
    .memreq_msg(memreq_msg_z), .memreq_domain(memreq_domain_z), .memreq_val(memreq_val_z), .memreq_rdy(memreq_rdy_z),
    .memresp_msg(memresp_msg_z), .memresp_domain(memresp_domain_z), .memresp_val(memresp_val_z), .memresp_rdy(memresp_rdy_z)
`ifdef PLAB3_MEM_NSBIT_CHECK_EN
    , .viol_count(viol_count_z)
`endif
  );

  typedef struct {
    logic         dom;
    logic [2:0]   typ;
    logic [7:0]   opq;
    logic [31:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
    logic [127:0] exp_data;
    logic [7:0]   exp_viol;
  } vec_t;

  typedef struct {
    logic         dom;
    logic [2:0]   typ;
    logic [7:0]   opq;
    logic [3:0]   len;
    logic [127:0] data;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic vec_t mkv(input logic dom, input logic [2:0] typ, input logic [7:0] opq,
                               input logic [31:0] addr, input logic [3:0] len, input logic [127:0] data,
                               input logic [127:0] exp_data, input logic [7:0] exp_viol);
    vec_t v;
    v.dom = dom; v.typ = typ; v.opq = opq; v.addr = addr; v.len = len;
    v.data = data; v.exp_data = exp_data; v.exp_viol = exp_viol;
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor on the main instance
  logic                    prev_val = 1'b0;
  logic [c_resp_nbits-1:0] prev_msg = '0;

  always @(negedge clk) begin
    if (reset) begin
      prev_val <= 1'b0;
    end else begin
      if (memresp_val) begin
        check("req_rdy_low_in_resp", memreq_rdy, 0);
        if (prev_val) begin
          check("resp_msg_stable", memresp_msg, prev_msg);
        end else begin
          check("resp_expected", exp_q.size(), 1);
          if (exp_q.size() != 0) check("resp_latency_cycle", cyc, exp_q[0].cyc);
        end
        if (memresp_rdy && exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("resp_type",   memresp_msg[142:140], mon_e.typ);
          check("resp_opaque", memresp_msg[139:132], mon_e.opq);
          check("resp_len",    memresp_msg[131:128], mon_e.len);
          check("resp_data",   memresp_msg[127:0],   mon_e.data);
          check("resp_domain", memresp_domain,       mon_e.dom);
        end
      end
      prev_val <= memresp_val && !memresp_rdy;
      prev_msg <= memresp_msg;
    end
  end

  task automatic send(input vec_t v);
    int k;
    memreq_msg    = {v.typ, v.opq, v.addr, v.len, v.data};
    memreq_domain = v.dom;
    memreq_val    = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!memreq_rdy && k < 50);
    check("req_accept_timeout", memreq_rdy, 1);
    if (memreq_rdy)
      exp_q.push_back('{dom: v.dom, typ: v.typ, opq: v.opq, len: v.len, data: v.exp_data, cyc: cyc + 2 + c_lat});
    @(posedge clk);
    #1;
    memreq_val = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    check("drain_timeout", exp_q.size(), 0);
    #1;
  endtask

  initial begin
    int k;
    logic [7:0] opqs [2];
    logic [31:0] addrs [2];
    memreq_msg = '0; memreq_domain = 1'b0; memreq_val = 1'b0; memresp_rdy = 1'b1;
    memreq_msg_z = '0; memreq_domain_z = 1'b0; memreq_val_z = 1'b0; memresp_rdy_z = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_resp_val", memresp_val, 0);
    check("reset_req_rdy", memreq_rdy, 1);
    check("reset_resp_val_z", memresp_val_z, 0);
    check("reset_req_rdy_z", memreq_rdy_z, 1);
`ifdef PLAB3_MEM_NSBIT_CHECK_EN
    check("reset_viol_count", viol_count, 0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;

    vecs.push_back(mkv(1, 3'd1, 8'h01, 32'h040,  4'd0, c_d1,            128'd0, 8'd0));
    vecs.push_back(mkv(1, 3'd0, 8'h02, 32'h040,  4'd0, 128'd0,          c_d1,   8'd0));
    vecs.push_back(mkv(1, 3'd1, 8'h03, 32'h030,  4'd0, c_all5,          128'd0, 8'd0));
    vecs.push_back(mkv(1, 3'd1, 8'h04, 32'h03E,  4'd4, 128'h44332211,   128'd0, 8'd0));
    vecs.push_back(mkv(1, 3'd0, 8'h05, 32'h030,  4'd0, 128'd0,          c_l30,  8'd0));
    vecs.push_back(mkv(1, 3'd0, 8'h06, 32'h040,  4'd8, 128'd0,          c_d1,   8'd0));
    vecs.push_back(mkv(1, 3'd0, 8'h07, 32'h440,  4'd0, 128'd0,          c_d1,   8'd0));
    vecs.push_back(mkv(1, 3'd1, 8'h08, 32'h445,  4'd1, 128'hEE,         128'd0, 8'd0));
    vecs.push_back(mkv(1, 3'd2, 8'h09, 32'h040,  4'd0, 128'd0,          c_d2,   8'd0));
    vecs.push_back(mkv(1, 3'd1, 8'h0A, 32'h200,  4'd0, c_all7,          128'd0, 8'd0));
`ifdef PLAB3_MEM_NSBIT_CHECK_EN
    vecs.push_back(mkv(0, 3'd1, 8'h0B, 32'h200,  4'd0, c_allA,          128'd0, 8'd1));
    vecs.push_back(mkv(1, 3'd0, 8'h0C, 32'h200,  4'd0, 128'd0,          c_all7, 8'd1));
    vecs.push_back(mkv(0, 3'd0, 8'h0D, 32'h200,  4'd0, 128'd0,          128'd0, 8'd2));
    vecs.push_back(mkv(0, 3'd0, 8'h0E, 32'h040,  4'd0, 128'd0,          c_d2,   8'd2));
    vecs.push_back(mkv(0, 3'd0, 8'h0F, 32'h600,  4'd0, 128'd0,          128'd0, 8'd3));
`else
    vecs.push_back(mkv(0, 3'd1, 8'h0B, 32'h200,  4'd0, c_allA,          128'd0, 8'd0));
    vecs.push_back(mkv(1, 3'd0, 8'h0C, 32'h200,  4'd0, 128'd0,          c_allA, 8'd0));
    vecs.push_back(mkv(0, 3'd0, 8'h0D, 32'h200,  4'd0, 128'd0,          c_allA, 8'd0));
    vecs.push_back(mkv(0, 3'd0, 8'h0E, 32'h040,  4'd0, 128'd0,          c_d2,   8'd0));
    vecs.push_back(mkv(0, 3'd0, 8'h0F, 32'h600,  4'd0, 128'd0,          c_allA, 8'd0));
`endif

    foreach (vecs[i]) begin
      send(vecs[i]);
      drain();
`ifdef PLAB3_MEM_NSBIT_CHECK_EN
      check($sformatf("viol_count_vec%0d", i), viol_count, vecs[i].exp_viol);
`endif
    end

    // Response stalled by the consumer for five cycles
    memresp_rdy = 1'b0;
    send(mkv(1, 3'd0, 8'h5A, 32'h040, 4'd0, 128'd0, c_d2, 8'd0));
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!memresp_val && k < 20);
    check("stall_resp_seen", memresp_val, 1);
    repeat (5) begin
      @(negedge clk);
      check("stall_val_held", memresp_val, 1);
    end
    @(posedge clk);
    #1;
    memresp_rdy = 1'b1;
    drain();
    @(negedge clk);
    check("req_rdy_after_handshake", memreq_rdy, 1);
    @(posedge clk);
    #1;

    // Reset while the read is waiting: no response, line contents survive
    send(mkv(1, 3'd0, 8'h77, 32'h040, 4'd0, 128'd0, c_d2, 8'd0));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("req_rdy_after_reset", memreq_rdy, 1);
    repeat (6) begin
      @(negedge clk);
      check("no_resp_after_reset", memresp_val, 0);
    end
    @(posedge clk);
    #1;
    send(mkv(1, 3'd0, 8'h78, 32'h040, 4'd0, 128'd0, c_d2, 8'd0));
    drain();

    // Zero-latency instance, back-to-back reads
    opqs[0] = 8'h11; opqs[1] = 8'h22;
    addrs[0] = 32'h0; addrs[1] = 32'h10;
    for (int i = 0; i < 2; i++) begin
      memreq_msg_z    = {3'd0, opqs[i], addrs[i], 4'd0, 128'd0};
      memreq_domain_z = 1'b1;
      memreq_val_z    = 1'b1;
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!memreq_rdy_z && k < 20);
      check("lat0_accept", memreq_rdy_z, 1);
      @(posedge clk);
      #1;
      memreq_val_z = 1'b0;
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!memresp_val_z && k < 20);
      check($sformatf("lat0_cycles_%0d", i), k, 2);
      check($sformatf("lat0_opaque_%0d", i), memresp_msg_z[139:132], opqs[i]);
      check($sformatf("lat0_type_%0d", i), memresp_msg_z[142:140], 3'd0);
      check($sformatf("lat0_domain_%0d", i), memresp_domain_z, 1);
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach summary, actual timeout required finish");
    $fatal(1);
  end

endmodule
